// File: rtl/md5_compress.sv
// MD5 compression core: one 512-bit block per 66 cycles (accept, 64 round steps, add).
// Chaining state persists across blocks until the final block emits the digest.
module md5_compress (
    input  logic           clk,
    input  logic           h_rst_n,
    input  logic           s_rst,
    input  logic [0:511]   block_in,
    input  logic           block_valid,
    input  logic           block_last,
    output logic           block_ready,
    output logic [127:0]   digest,
    output logic           digest_valid
);

    typedef enum logic [1:0] {IDLE, ROUND, ADD} state_e;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;

    state_e             state_q;
    logic [5:0]         step_q;
    logic [31:0]        h0_q, h1_q, h2_q, h3_q;
    logic [31:0]        a_q, b_q, c_q, d_q;
    logic [15:0][31:0]  m_q;
    logic               last_q;
    logic               ready_q;
    logic [127:0]       digest_q;
    logic               dvalid_q;

    logic [15:0][31:0]  blk_words;
    logic [31:0]        f_val, k_val, sum, rot, tmp;
    logic [3:0]         g_idx;
    logic [4:0]         rot_amt;
    logic [31:0]        s0, s1, s2, s3;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] i);
        case (i)
            6'd0:  return 32'hd76aa478;  6'd1:  return 32'he8c7b756;
            6'd2:  return 32'h242070db;  6'd3:  return 32'hc1bdceee;
            6'd4:  return 32'hf57c0faf;  6'd5:  return 32'h4787c62a;
            6'd6:  return 32'ha8304613;  6'd7:  return 32'hfd469501;
            6'd8:  return 32'h698098d8;  6'd9:  return 32'h8b44f7af;
            6'd10: return 32'hffff5bb1;  6'd11: return 32'h895cd7be;
            6'd12: return 32'h6b901122;  6'd13: return 32'hfd987193;
            6'd14: return 32'ha679438e;  6'd15: return 32'h49b40821;
            6'd16: return 32'hf61e2562;  6'd17: return 32'hc040b340;
            6'd18: return 32'h265e5a51;  6'd19: return 32'he9b6c7aa;
            6'd20: return 32'hd62f105d;  6'd21: return 32'h02441453;
            6'd22: return 32'hd8a1e681;  6'd23: return 32'he7d3fbc8;
            6'd24: return 32'h21e1cde6;  6'd25: return 32'hc33707d6;
            6'd26: return 32'hf4d50d87;  6'd27: return 32'h455a14ed;
            6'd28: return 32'ha9e3e905;  6'd29: return 32'hfcefa3f8;
            6'd30: return 32'h676f02d9;  6'd31: return 32'h8d2a4c8a;
            6'd32: return 32'hfffa3942;  6'd33: return 32'h8771f681;
            6'd34: return 32'h6d9d6122;  6'd35: return 32'hfde5380c;
            6'd36: return 32'ha4beea44;  6'd37: return 32'h4bdecfa9;
            6'd38: return 32'hf6bb4b60;  6'd39: return 32'hbebfbc70;
            6'd40: return 32'h289b7ec6;  6'd41: return 32'heaa127fa;
            6'd42: return 32'hd4ef3085;  6'd43: return 32'h04881d05;
            6'd44: return 32'hd9d4d039;  6'd45: return 32'he6db99e5;
            6'd46: return 32'h1fa27cf8;  6'd47: return 32'hc4ac5665;
            6'd48: return 32'hf4292244;  6'd49: return 32'h432aff97;
            6'd50: return 32'hab9423a7;  6'd51: return 32'hfc93a039;
            6'd52: return 32'h655b59c3;  6'd53: return 32'h8f0ccc92;
            6'd54: return 32'hffeff47d;  6'd55: return 32'h85845dd1;
            6'd56: return 32'h6fa87e4f;  6'd57: return 32'hfe2ce6e0;
            6'd58: return 32'ha3014314;  6'd59: return 32'h4e0811a1;
            6'd60: return 32'hf7537e82;  6'd61: return 32'hbd3af235;
            6'd62: return 32'h2ad7d2bb;  default: return 32'heb86d391;
        endcase
    endfunction

    // Message bytes arrive big-endian in the vector; MD5 words are little-endian.
    always_comb begin
        blk_words = '0;
        for (int j = 0; j < 16; j++)
            blk_words[j] = {block_in[32*j+24 +: 8], block_in[32*j+16 +: 8],
                            block_in[32*j+8 +: 8],  block_in[32*j +: 8]};
    end

    always_comb begin
        f_val = 32'd0;
        g_idx = 4'd0;
        case (step_q[5:4])
            2'd0: begin f_val = (b_q & c_q) | (~b_q & d_q); g_idx = step_q[3:0]; end
            2'd1: begin f_val = (d_q & b_q) | (~d_q & c_q); g_idx = step_q[3:0] * 4'd5 + 4'd1; end
            2'd2: begin f_val = b_q ^ c_q ^ d_q;             g_idx = step_q[3:0] * 4'd3 + 4'd5; end
            default: begin f_val = c_q ^ (b_q | ~d_q);       g_idx = step_q[3:0] * 4'd7; end
        endcase
    end

    // Rotation depends only on the round and the step position within a group of four.
    always_comb begin
        case ({step_q[5:4], step_q[1:0]})
            4'h0: rot_amt = 5'd7;   4'h1: rot_amt = 5'd12;
            4'h2: rot_amt = 5'd17;  4'h3: rot_amt = 5'd22;
            4'h4: rot_amt = 5'd5;   4'h5: rot_amt = 5'd9;
            4'h6: rot_amt = 5'd14;  4'h7: rot_amt = 5'd20;
            4'h8: rot_amt = 5'd4;   4'h9: rot_amt = 5'd11;
            4'ha: rot_amt = 5'd16;  4'hb: rot_amt = 5'd23;
            4'hc: rot_amt = 5'd6;   4'hd: rot_amt = 5'd10;
            4'he: rot_amt = 5'd15;  default: rot_amt = 5'd21;
        endcase
    end

    assign k_val = k_const(step_q);
    assign sum   = a_q + f_val + k_val + m_q[g_idx];
    assign rot   = (sum << rot_amt) | (sum >> (6'd32 - {1'b0, rot_amt}));
    assign tmp   = b_q + rot;

    assign s0 = h0_q + a_q;
    assign s1 = h1_q + b_q;
    assign s2 = h2_q + c_q;
    assign s3 = h3_q + d_q;

    always_ff @(posedge clk or negedge h_rst_n) begin
        if (!h_rst_n) begin
            state_q  <= IDLE;
            step_q   <= 6'd0;
            h0_q     <= IV0;
            h1_q     <= IV1;
            h2_q     <= IV2;
            h3_q     <= IV3;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else if (s_rst) begin
            state_q  <= IDLE;
            step_q   <= 6'd0;
            h0_q     <= IV0;
            h1_q     <= IV1;
            h2_q     <= IV2;
            h3_q     <= IV3;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (block_valid) begin
                        m_q      <= blk_words;
                        last_q   <= block_last;
                        a_q      <= h0_q;
                        b_q      <= h1_q;
                        c_q      <= h2_q;
                        d_q      <= h3_q;
                        step_q   <= 6'd0;
                        dvalid_q <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= ROUND;
                    end
                end
                ROUND: begin
                    a_q    <= d_q;
                    d_q    <= c_q;
                    c_q    <= b_q;
                    b_q    <= tmp;
                    step_q <= step_q + 6'd1;
                    if (step_q == 6'd63)
                        state_q <= ADD;
                end
                ADD: begin
                    if (last_q) begin
                        digest_q <= {bswap(s0), bswap(s1), bswap(s2), bswap(s3)};
                        dvalid_q <= 1'b1;
                        h0_q     <= IV0;
                        h1_q     <= IV1;
                        h2_q     <= IV2;
                        h3_q     <= IV3;
                    end else begin
                        h0_q <= s0;
                        h1_q <= s1;
                        h2_q <= s2;
                        h3_q <= s3;
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign block_ready  = ready_q;
    assign digest       = digest_q;
    assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_md5_compress.sv
// Bench for md5_compress: a transaction-level MD5 model with cycle timing is compared
// against the DUT every cycle, plus directed known-answer and reset scenarios.
module tb_md5_compress;

    logic         clk = 1'b0;
    logic         h_rst_n = 1'b0;
    logic         s_rst = 1'b0;
    logic [0:511] block_in = '0;
    logic         block_valid = 1'b0;
    logic         block_last = 1'b0;
    logic         block_ready;
    logic [127:0] digest;
    logic         digest_valid;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    md5_compress dut (
        .clk          (clk),
        .h_rst_n      (h_rst_n),
        .s_rst        (s_rst),
        .block_in     (block_in),
        .block_valid  (block_valid),
        .block_last   (block_last),
        .block_ready  (block_ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_80    = 128'h57edf4a22be3c955ac49da2e2107b67a;

    // Straight RFC 1321 block transform on the chaining value {H0,H1,H2,H3}.
    function automatic logic [127:0] md5_block(input logic [127:0] h, input logic [0:511] b);
        logic [31:0] m [16];
        logic [31:0] a, bb, c, d, f, x, t;
        int g, s;
        for (int j = 0; j < 16; j++)
            m[j] = {b[32*j+24 +: 8], b[32*j+16 +: 8], b[32*j+8 +: 8], b[32*j +: 8]};
        a = h[127:96]; bb = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (bb & c) | (~bb & d); g = i;              end
            else if (i < 32) begin f = (d & bb) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = bb ^ c ^ d;           g = (3*i + 5) % 16; end
            else             begin f = c ^ (bb | ~d);        g = (7*i) % 16;     end
            s = ST[(i/16)*4 + i%4];
            x = a + f + KT[i] + m[g];
            x = (x << s) | (x >> (32 - s));
            t = bb + x;
            a = d; d = c; c = bb; bb = t;
        end
        return {h[127:96] + a, h[95:64] + bb, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [127:0] to_digest(input logic [127:0] h);
        logic [127:0] r;
        logic [31:0] w;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            w = h[127-32*k -: 32];
            r[127-32*k -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return r;
    endfunction

    // Block k of the standard MD5 padding of string s.
    function automatic logic [0:511] msg_block(input string s, input int k);
        logic [0:511] r;
        logic [63:0] bits;
        logic [7:0] v;
        int n, nb, q;
        r = '0;
        n = s.len();
        nb = ((n + 8) / 64) + 1;
        bits = 64'(n) * 64'd8;
        for (int p = 0; p < 64; p++) begin
            q = 64*k + p;
            v = 8'h00;
            if (q < n) v = s[q];
            else if (q == n) v = 8'h80;
            else if (q >= nb*64 - 8) v = bits[8*(q - (nb*64 - 8)) +: 8];
            r[8*p +: 8] = v;
        end
        return r;
    endfunction

    // Cycle-timed model: a block accepted when idle completes 65 edges later.
    int           m_cnt = 0;
    logic [127:0] m_h = IV;
    logic [127:0] m_pend = '0;
    logic [127:0] m_dig = '0;
    logic         m_dv = 1'b0;
    logic         m_last = 1'b0;

    always @(posedge clk or negedge h_rst_n) begin
        if (!h_rst_n || s_rst) begin
            m_cnt <= 0;
            m_h   <= IV;
            m_dig <= '0;
            m_dv  <= 1'b0;
        end else if (m_cnt == 0) begin
            if (block_valid) begin
                m_pend <= md5_block(m_h, block_in);
                m_last <= block_last;
                m_dv   <= 1'b0;
                m_cnt  <= 65;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                if (m_last) begin
                    m_dig <= to_digest(m_pend);
                    m_dv  <= 1'b1;
                    m_h   <= IV;
                end else begin
                    m_h <= m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_cnt++;
            if (block_ready !== (m_cnt == 0) || digest_valid !== m_dv || digest !== m_dig) begin
                err_cnt++;
                $display("FAIL cycle_check t=%0t: got ready=%b dv=%b dig=%h, expected ready=%b dv=%b dig=%h",
                         $time, block_ready, digest_valid, digest, (m_cnt == 0), m_dv, m_dig);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+2; the block is accepted on the next edge that sees ready.
    task automatic send(input logic [0:511] blk, input logic last);
        int n;
        n = 0;
        while (!block_ready && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 500) check("send_timeout", 128'(n), 128'd0);
        block_in    = blk;
        block_last  = last;
        block_valid = 1'b1;
        @(posedge clk); #2;
        block_valid = 1'b0;
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        while (!digest_valid && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!block_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    string s80;
    logic [127:0] hmid;
    logic [0:511] junk;
    int lat;

    initial begin
        s80 = "";
        for (int r = 0; r < 8; r++) s80 = {s80, "1234567890"};

        h_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        h_rst_n = 1'b1;
        chk_en  = 1'b1;

        check("model_abc",   to_digest(md5_block(IV, msg_block("abc", 0))), D_ABC);
        check("model_empty", to_digest(md5_block(IV, msg_block("", 0))), D_EMPTY);
        hmid = md5_block(IV, msg_block(s80, 0));
        check("model_80",    to_digest(md5_block(hmid, msg_block(s80, 1))), D_80);

        check("reset_ready",  128'(block_ready), 128'd1);
        check("reset_dv",     128'(digest_valid), 128'd0);
        check("reset_digest", digest, 128'd0);

        send(msg_block("abc", 0), 1'b1);
        wait_dv(lat);
        check("abc_latency", 128'(lat), 128'd65);
        check("abc_digest",  digest, D_ABC);
        check("abc_ready",   128'(block_ready), 128'd1);

        send(msg_block("", 0), 1'b1);
        check("empty_dv_clear", 128'(digest_valid), 128'd0);
        wait_dv(lat);
        check("empty_digest", digest, D_EMPTY);

        send(msg_block(s80, 0), 1'b0);
        wait_ready(lat);
        check("blk1_ready_lat", 128'(lat), 128'd65);
        check("blk1_dv_low",    128'(digest_valid), 128'd0);
        send(msg_block(s80, 1), 1'b1);
        wait_dv(lat);
        check("two_block_digest", digest, D_80);

        // A different block held valid while busy must not disturb the hash.
        send(msg_block("abc", 0), 1'b1);
        for (int w = 0; w < 16; w++) junk[32*w +: 32] = $urandom();
        block_in = junk;
        block_last = 1'b1;
        block_valid = 1'b1;
        repeat (55) @(posedge clk);
        #2;
        block_valid = 1'b0;
        wait_dv(lat);
        check("busy_valid_ignored", digest, D_ABC);

        // Hard reset in the middle of round 2.
        send(msg_block("abc", 0), 1'b1);
        repeat (30) @(posedge clk);
        #2;
        h_rst_n = 1'b0;
        #1;
        check("hrst_digest", digest, 128'd0);
        check("hrst_dv",     128'(digest_valid), 128'd0);
        check("hrst_ready",  128'(block_ready), 128'd1);
        @(posedge clk); #2;
        h_rst_n = 1'b1;
        send(msg_block("abc", 0), 1'b1);
        wait_dv(lat);
        check("after_hrst_abc", digest, D_ABC);

        // Soft reset coincident with a valid block wins over the accept.
        send(msg_block("abc", 0), 1'b1);
        repeat (40) @(posedge clk);
        #2;
        s_rst = 1'b1;
        block_valid = 1'b1;
        block_in = msg_block("", 0);
        @(posedge clk); #2;
        s_rst = 1'b0;
        block_valid = 1'b0;
        check("srst_ready",  128'(block_ready), 128'd1);
        check("srst_dv",     128'(digest_valid), 128'd0);
        check("srst_digest", digest, 128'd0);
        repeat (70) @(posedge clk);
        #2;
        check("srst_no_accept", 128'(digest_valid), 128'd0);

        // Randomized traffic, including valid-while-busy and sporadic resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            block_valid = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < 16; w++) block_in[32*w +: 32] = $urandom();
            block_last = 1'($urandom_range(0, 1));
            s_rst = ($urandom_range(0, 299) == 0);
            h_rst_n = ($urandom_range(0, 599) != 0);
            @(posedge clk); #2;
        end
        block_valid = 1'b0;
        s_rst = 1'b0;
        h_rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
